// File: rtl/store_buffer_if.sv
// Memory write bus between the store buffer and the data memory.
//
// Handshake: the buffer (master) raises mem_wvalid while it holds a
// write and keeps mem_addr/mem_wdata/mem_byteen stable until the memory
// (slave) accepts it. A write transfers on any rising edge where both
// mem_wvalid and mem_wready are high. mem_wready may be asserted at any
// time. The master never derives its outputs combinationally from
// mem_wready.
interface store_buffer_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic        mem_wvalid;
  logic        mem_wready;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_byteen,
    output mem_wvalid,
    input  mem_wready
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_byteen,
    input  mem_wvalid,
    output mem_wready
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer: queues aligned stores from the MEM stage,
// merges a store into the newest entry when both hit the same word, and
// drains entries in order to the memory write bus. Stalls the pipeline
// when full or when a load hits a word that still has a pending store.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [3:0]       st_byteen,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic             stall,
  store_buffer_if.master   mem,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [29:0]      addr_q  [DEPTH];
  logic [31:0]      data_q  [DEPTH];
  logic [3:0]       be_q    [DEPTH];
  logic [DEPTH-1:0] valid_q;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] tail_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic nonempty;
  logic push_req;
  logic pop;
  logic coal;
  logic enq;
  logic full_stall;
  logic ld_hit;

  // Byte-offset bits of the addresses do not matter at word granularity.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  assign nonempty = (cnt_q != '0);
  assign tail_idx = tail_q - PTR_W'(1);
  assign push_req = st_valid & (|st_byteen);
  assign pop      = nonempty & mem.mem_wready;

  // Merging needs at least two entries so the tail is never the head
  // currently presented on the bus.
  assign coal = push_req && (cnt_q >= CNT_W'(2)) &&
                (addr_q[tail_idx] == st_addr[31:2]);

  // A full buffer still accepts a store when the head leaves this cycle.
  assign enq        = push_req & ~coal & ((cnt_q != CNT_W'(DEPTH)) | pop);
  assign full_stall = push_req & ~coal & (cnt_q == CNT_W'(DEPTH)) & ~pop;

  // Load hazard search over pending entries; a head popping now no longer counts.
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == ld_addr[31:2]) &&
          !(pop && (head_q == PTR_W'(i)))) begin
        ld_hit = 1'b1;
      end
    end
  end

  // A simultaneous store wins; the load check is ignored in that case.
  assign stall = full_stall | (ld_valid & ~st_valid & ld_hit);

  // Next-state pointers and occupancy.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop) head_d = head_q + PTR_W'(1);
    if (enq) tail_d = tail_q + PTR_W'(1);
    if (enq && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !enq) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage: pop clears first so a full-buffer enqueue into the
  // slot being vacated keeps its valid bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      if (pop) valid_q[head_q] <= 1'b0;
      if (enq) begin
        addr_q[tail_q]  <= st_addr[31:2];
        data_q[tail_q]  <= st_data;
        be_q[tail_q]    <= st_byteen;
        valid_q[tail_q] <= 1'b1;
      end
      if (coal) begin
        for (int b = 0; b < 4; b++) begin
          if (st_byteen[b]) begin
            data_q[tail_idx][8*b +: 8] <= st_data[8*b +: 8];
            be_q[tail_idx][b]          <= 1'b1;
          end
        end
      end
    end
  end

  // Head entry presentation; all zero while the buffer is empty.
  always_comb begin
    mem.mem_wvalid = nonempty;
    mem.mem_addr   = '0;
    mem.mem_wdata  = '0;
    mem.mem_byteen = '0;
    if (nonempty) begin
      mem.mem_addr   = {addr_q[head_q], 2'b00};
      mem.mem_wdata  = data_q[head_q];
      mem.mem_byteen = be_q[head_q];
    end
  end

  assign empty = ~nonempty;
  assign count = cnt_q;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of pending writes.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int W     = 66; // {word addr[29:0], data[31:0], byteen[3:0]}

  logic             clk;
  logic             reset;
  logic             st_valid;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic [3:0]       st_byteen;
  logic             ld_valid;
  logic [31:0]      ld_addr;
  logic             stall;
  logic             empty;
  logic [CNT_W-1:0] count;

  store_buffer_if mif();

  store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_byteen (st_byteen),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .stall     (stall),
    .mem       (mif.master),
    .empty     (empty),
    .count     (count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Pending writes, oldest first.
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, check against the model, advance the model.
  task automatic cycle(input logic stv, input logic [31:0] sta, input logic [31:0] std,
                       input logic [3:0] stb, input logic ldv, input logic [31:0] lda,
                       input logic wr);
    int n;
    logic pop, push, coal, enq, hz, exp_stall;
    logic [W-1:0] e;
    st_valid = stv; st_addr = sta; st_data = std; st_byteen = stb;
    ld_valid = ldv; ld_addr = lda; mif.mem_wready = wr;
    #1;
    n    = exp_q.size();
    pop  = (n > 0) && wr;
    push = stv && (stb != 4'b0000);
    coal = push && (n >= 2) && (exp_q[n-1][65:36] == sta[31:2]);
    enq  = push && !coal && ((n < DEPTH) || pop);
    hz   = 1'b0;
    for (int k = (pop ? 1 : 0); k < n; k++)
      if (exp_q[k][65:36] == lda[31:2]) hz = 1'b1;
    exp_stall = (push && !coal && (n == DEPTH) && !pop) || (ldv && !stv && hz);
    chk("stall",  {31'b0, stall}, {31'b0, exp_stall});
    chk("wvalid", {31'b0, mif.mem_wvalid}, {31'b0, (n > 0)});
    chk("count",  32'(count), 32'(n));
    chk("empty",  {31'b0, empty}, {31'b0, (n == 0)});
    if (n > 0) begin
      e = exp_q[0];
      chk("mem_addr",   mif.mem_addr, {e[65:36], 2'b00});
      chk("mem_wdata",  mif.mem_wdata, e[35:4]);
      chk("mem_byteen", {28'b0, mif.mem_byteen}, {28'b0, e[3:0]});
    end
    @(posedge clk);
    if (coal) begin
      e = exp_q[n-1];
      for (int b = 0; b < 4; b++)
        if (stb[b]) begin
          e[4 + 8*b +: 8] = std[8*b +: 8];
          e[b] = 1'b1;
        end
      exp_q[n-1] = e;
    end
    if (pop) void'(exp_q.pop_front());
    if (enq) exp_q.push_back({sta[31:2], std, stb});
    @(negedge clk);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic wr);
    cycle(1'b1, a, d, be, 1'b0, 32'h0, wr);
  endtask

  task automatic load(input logic [31:0] a, input logic wr);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a, wr);
  endtask

  task automatic idle(input logic wr);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, wr);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1'b1);
    chk("drained", 32'(count), 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_byteen = '0;
    ld_valid = 1'b0; ld_addr = '0; mif.mem_wready = 1'b0;
    #3;
    chk("rst_wvalid", {31'b0, mif.mem_wvalid}, 32'h0);
    chk("rst_count",  32'(count), 32'h0);
    chk("rst_empty",  {31'b0, empty}, 32'h1);
    chk("rst_stall",  {31'b0, stall}, 32'h0);
    chk("rst_addr",   mif.mem_addr, 32'h0);
    chk("rst_wdata",  mif.mem_wdata, 32'h0);
    chk("rst_byteen", {28'b0, mif.mem_byteen}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Single store, first-cycle latency, then drain.
    store(32'h10, 32'h000000AB, 4'b0001, 1'b0);
    chk("lat_addr", mif.mem_addr, 32'h10);
    chk("lat_count", 32'(count), 32'h1);
    idle(1'b1);
    chk("single_empty", {31'b0, empty}, 32'h1);

    // Fill, full stall, accept on same-cycle pop.
    store(32'h0, 32'h01010101, 4'hF, 1'b0);
    store(32'h4, 32'h02020202, 4'hF, 1'b0);
    store(32'h8, 32'h03030303, 4'hF, 1'b0);
    store(32'hC, 32'h04040404, 4'hF, 1'b0);
    chk("full_count", 32'(count), 32'h4);
    store(32'h20, 32'h05050505, 4'hF, 1'b0);
    chk("full_hold", 32'(count), 32'h4);
    store(32'h20, 32'h05050505, 4'hF, 1'b1);
    chk("full_head", mif.mem_addr, 32'h4);
    chk("full_after", 32'(count), 32'h4);
    drain();

    // Coalescing into the tail.
    store(32'h100, 32'h00001234, 4'b0011, 1'b0);
    store(32'h200, 32'h11111111, 4'b1111, 1'b0);
    store(32'h202, 32'h00CC0000, 4'b0100, 1'b0);
    chk("coal_count", 32'(count), 32'h2);
    idle(1'b1);
    chk("coal_wdata", mif.mem_wdata, 32'h11CC1111);
    chk("coal_byteen", {28'b0, mif.mem_byteen}, 32'hF);
    drain();

    // Empty byte-enable store is dropped.
    store(32'h40, 32'hDEADBEEF, 4'b0000, 1'b0);
    chk("nobe_count", 32'(count), 32'h0);

    // Load hazard.
    store(32'h80, 32'h0000AA00, 4'b0010, 1'b0);
    load(32'h83, 1'b0);
    load(32'h84, 1'b0);
    load(32'h83, 1'b1);
    drain();

    // Asynchronous reset mid-drain.
    store(32'h300, 32'h1, 4'hF, 1'b0);
    store(32'h304, 32'h2, 4'hF, 1'b0);
    store(32'h308, 32'h3, 4'hF, 1'b0);
    store(32'h30C, 32'h4, 4'hF, 1'b1);
    st_valid = 1'b0; ld_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("arst_wvalid", {31'b0, mif.mem_wvalid}, 32'h0);
    chk("arst_count",  32'(count), 32'h0);
    chk("arst_empty",  {31'b0, empty}, 32'h1);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Random traffic over a small word set to exercise merges and hazards.
    for (int i = 0; i < 600; i++) begin
      logic stv, ldv, wr;
      logic [31:0] a, la;
      stv = ($urandom_range(0, 99) < 55);
      ldv = stv ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 99) < 50);
      wr  = ($urandom_range(0, 99) < 40);
      a   = 32'h1000 + (32'($urandom_range(0, 5)) << 2) + 32'($urandom_range(0, 3));
      la  = 32'h1000 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      cycle(stv, a, $urandom, 4'($urandom_range(0, 15)), ldv, la, wr);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the store byte-enable stage and the data memory bus.
- Accepts already-aligned store data and byte-enables from the MEM stage, queues them in a small FIFO, and drains them to memory with a valid/ready handshake.
- Coalesces a store into the newest queued entry when both target the same word.
- Stalls the pipeline when the FIFO is full, and stalls a load that hits a pending store's word.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- CNT_W, 3, width of `count`; equals log2(DEPTH)+1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `st_valid`  in  1  MEM stage holds a store instruction.
- `st_addr`  in  32  store byte address; only [31:2] is stored.
- `st_data`  in  32  lane-aligned store data.
- `st_byteen`  in  4  byte lanes to write; 4'b0000 means no write, and the store is dropped.
- `ld_valid`  in  1  MEM stage holds a load instruction.
- `ld_addr`  in  32  load byte address.
- `stall`  out  1  freeze IF..MEM this cycle; combinational.
- `mem_addr`  out  32  head entry word address, {addr[31:2], 2'b00}.
- `mem_wdata`  out  32  head entry data.
- `mem_byteen`  out  4  head entry byte-enables.
- `mem_wvalid`  out  1  head entry valid (buffer not empty).
- `mem_wready`  in  1  memory accepts the head this cycle.
- `empty`  out  1  no entries held.
- `count`  out  CNT_W  entries held, 0..DEPTH.

Behaviour:
- **Reset** (reset=0, asynchronous):
  - head and tail pointers = 0, count = 0, all entry valid bits = 0.
  - `mem_wvalid`=0, `mem_byteen`=0, `mem_addr`=0, `mem_wdata`=0, `empty`=1, `stall`=0.
  - Reset mid-drain discards all entries; no further `mem_wvalid` until a new store arrives.
- **Definitions:**
  - push_req = `st_valid` & (|`st_byteen`).
  - pop = `mem_wvalid` & `mem_wready`.
  - tail_idx = tail-1 (newest entry).
- **Coalesce:** push_req, count≥2, and tail entry addr[31:2] == `st_addr`[31:2].
  - count ≥2 guarantees the tail is not the head being presented.
  - Per lane i with `st_byteen`[i]=1: tail data byte i ← `st_data` byte i and byteen[i] ← 1. Other lanes are unchanged.
  - count is unchanged.
  - Allowed when full; no stall.
- **Enqueue:** push_req, not coalesce, and (count<DEPTH or pop).
  - Write {addr, data, byteen} at tail; tail++ (wraps modulo DEPTH).
  - Full plus same-cycle pop accepts the store with no stall.
- **Full stall:** push_req, not coalesce, count==DEPTH, and not pop → `stall`=1.
  - The store is not written; MEM holds and re-presents it next cycle.
- **Load hazard:** `ld_valid` and any valid entry with addr[31:2]==`ld_addr`[31:2] → `stall`=1 until that entry drains.
  - The comparison excludes the head entry if it pops this cycle.
- `st_valid` and `ld_valid` high together is illegal. The store path takes priority and the load check is ignored.
- **Drain:**
  - `mem_*` outputs reflect the head entry whenever count>0; `mem_wvalid` = (count>0).
  - The head holds stable until pop; on pop, head++ with wrap.
  - At most one pop per cycle; no combinational path from `mem_wready` to `mem_*`.
- **Count update:** count_next = count + enqueue − pop. Enqueue and pop in the same cycle leave count unchanged.
- Coalesce into the tail is never blocked by a pop of the head in the same cycle.
- **Latency:** a store accepted at edge N appears on `mem_*` at N+1 if the buffer was empty.
- `empty` = (count==0).

Test Plan:
- Reset, then store addr=0x10, data=0x000000AB, byteen=0001 with `mem_wready`=0 → next cycle `mem_wvalid`=1, `mem_addr`=0x10, `mem_byteen`=0001, count=1. Raise `mem_wready` → count=0, `empty`=1.
- Hold `mem_wready`=0 and push 4 stores to distinct words 0x0/0x4/0x8/0xC → count=4. A 5th store to 0x20 gives `stall`=1 with count staying 4. Pulse `mem_wready` once → the 5th store is accepted that cycle, `stall`=0, head=0x4.
- `mem_wready`=0 and stores 0x100 (0011, 0x00001234) then 0x200 (1111, 0x11111111), then 0x202 (0100, 0x00CC0000) → count=2. After draining, the second write shows `mem_byteen`=1111 and `mem_wdata`=0x11CC1111.
- Store byteen=0000 (addr 0x40) → no enqueue, count unchanged, `stall`=0.
- Pending store to 0x80, `mem_wready`=0, load `ld_addr`=0x83 → `stall`=1. Load 0x84 → `stall`=0. Raise `mem_wready` → the 0x83 load unstalls the same cycle the head pops.
- Assert reset low with 3 pending entries mid-drain → `mem_wvalid`=0 and count=0 immediately (asynchronous), with no writes after release.
